// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a double-buffered BCD word.
// Define SEG_SCAN_LZB_EN to blank leading zero digits.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              seg_bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t                       state;
  logic [NUM_DIGITS-1:0][3:0]   pending;
  logic [NUM_DIGITS-1:0][3:0]   active;
  logic [IW-1:0]                idx;
  logic [CW-1:0]                cnt;

  logic blank_end;
  logic show_end;
  logic last;
  logic xfer;

  assign blank_end = (state == BLANK) &&
                     (cnt == CW'(BLANK_CYCLES - 1));
  assign show_end  = (state == SHOW) &&
                     (cnt == CW'(REFRESH_DIV - 1));
  assign last      = (idx == IW'(NUM_DIGITS - 1));
  // Display buffer only swaps at a frame boundary, so no frame tears.
  assign xfer      = enable &&
                     ((state == IDLE) || (show_end && last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      pending    <= '0;
      active     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= enable && show_end && last;
      if (load)
        pending <= digits_in;
      if (xfer)
        active <= load ? digits_in : pending;
      if (!enable) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
          end
          BLANK: begin
            if (blank_end) begin
              state <= SHOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHOW: begin
            if (show_end) begin
              state <= BLANK;
              cnt   <= '0;
              idx   <= last ? '0 : idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // lz[i]: digit i and every digit above it are zero.
  logic [NUM_DIGITS-1:0] lz;

  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (active[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--)
      lz[i] = lz[i+1] && (active[i] == 4'd0);
  end
`endif

  always_comb begin
    an      = '1;
    seg_bcd = '0;
    if (state != IDLE)
      seg_bcd = active[idx];
    if (state == SHOW) begin
`ifdef SEG_SCAN_LZB_EN
      an[idx] = lz[idx];
`else
      an[idx] = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: reset, scan order, buffering,
// enable/reset interruption and (when enabled) leading-zero blanking.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  seg_bcd;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .seg_bcd   (seg_bcd),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    load   = 1'b0;
    rst    = 1'b1;
    step();
    rst    = 1'b0;
    step();
  endtask

  // Loads val into pending, then raises enable; the next step is cycle 0.
  task automatic start(input logic [15:0] val);
    digits_in = val;
    load      = 1'b1;
    step();
    load      = 1'b0;
    enable    = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    rst    = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (an !== 4'hF || seg_bcd !== 4'h0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_held: an=%b seg=%h fd=%b want 1111 0 0",
                 an, seg_bcd, frame_done);
      end
      step();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg_bcd !== 4'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: an=%b seg=%h fd=%b want 1111 0 0",
               an, seg_bcd, frame_done);
    end
    step();
    checks++;
    if (an !== 4'hF || seg_bcd !== 4'h0) begin
      errors++;
      $display("FAIL reset_first_blank: an=%b seg=%h want 1111 0",
               an, seg_bcd);
    end
    enable = 1'b0;
  endtask

  task automatic test_basic_scan();
    logic [15:0] val;
    logic [3:0]  ea;
    logic [3:0]  es;
    int          d;
    do_reset();
    val = 16'h1234;
    start(val);
    for (int c = 0; c < 49; c++) begin
      step();
      d  = (c % 24) / 6;
      ea = 4'hF;
      if ((c % 6) >= 2) ea[d] = 1'b0;
      es = val[d*4 +: 4];
      checks++;
      if (an !== ea || seg_bcd !== es) begin
        errors++;
        $display("FAIL basic_scan c=%0d: an=%b seg=%h want %b %h",
                 c, an, seg_bcd, ea, es);
      end
      checks++;
      if (frame_done !== (c == 24 || c == 48)) begin
        errors++;
        $display("FAIL basic_frame_done c=%0d: got %b want %b",
                 c, frame_done, (c == 24 || c == 48));
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] cur;
    logic [3:0]  es;
    int          d;
    do_reset();
    v1 = 16'h1234;
    v2 = 16'h5678;
    start(v1);
    for (int c = 0; c < 48; c++) begin
      step();
      d   = (c % 24) / 6;
      cur = (c < 24) ? v1 : v2;
      es  = cur[d*4 +: 4];
      checks++;
      if (seg_bcd !== es) begin
        errors++;
        $display("FAIL no_tearing c=%0d: seg=%h want %h", c, seg_bcd, es);
      end
      // c=8 is digit 1 SHOW; capture lands on the edge into c=9
      if (c == 8) begin
        digits_in = v2;
        load      = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_load_boundary();
    logic [15:0] val;
    logic [3:0]  es;
    int          d;
    do_reset();
    val = 16'h1234;
    start(val);
    for (int c = 0; c < 48; c++) begin
      step();
      d  = (c % 24) / 6;
      es = (c < 24) ? val[d*4 +: 4] : 4'h9;
      checks++;
      if (seg_bcd !== es) begin
        errors++;
        $display("FAIL load_boundary c=%0d: seg=%h want %h",
                 c, seg_bcd, es);
      end
      if (c == 24) begin
        checks++;
        if (dut.active !== 16'h9999 || dut.pending !== 16'h9999) begin
          errors++;
          $display("FAIL boundary_buffers: active=%h pending=%h want 9999",
                   dut.active, dut.pending);
        end
      end
      // c=23 is the last SHOW cycle of digit 3
      if (c == 23) begin
        digits_in = 16'h9999;
        load      = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_enable_reset();
    do_reset();
    start(16'h1234);
    for (int c = 0; c < 16; c++) step();
    checks++;
    if (an !== 4'b1011 || seg_bcd !== 4'h2) begin
      errors++;
      $display("FAIL en_pre_drop: an=%b seg=%h want 1011 2", an, seg_bcd);
    end
    enable = 1'b0;
    step();
    checks++;
    if (an !== 4'hF || seg_bcd !== 4'h0 || dut.idx !== '0 ||
        dut.cnt !== '0) begin
      errors++;
      $display("FAIL en_drop: an=%b seg=%h idx=%0d cnt=%0d want 1111 0 0 0",
               an, seg_bcd, dut.idx, dut.cnt);
    end
    step();
    enable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 2) begin
        checks++;
        if (an !== 4'b1110 || seg_bcd !== 4'h4) begin
          errors++;
          $display("FAIL en_restart: an=%b seg=%h want 1110 4",
                   an, seg_bcd);
        end
      end
    end
    checks++;
    if (an !== 4'hF || seg_bcd !== 4'h3) begin
      errors++;
      $display("FAIL en_blank_d1: an=%b seg=%h want 1111 3", an, seg_bcd);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg_bcd !== 4'h0 || frame_done !== 1'b0 ||
        dut.idx !== '0 || dut.active !== 16'h0) begin
      errors++;
      $display("FAIL async_rst: an=%b seg=%h fd=%b idx=%0d act=%h",
               an, seg_bcd, frame_done, dut.idx, dut.active);
    end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (an !== 4'b1110 || seg_bcd !== 4'h0) begin
      errors++;
      $display("FAIL rst_restart: an=%b seg=%h want 1110 0", an, seg_bcd);
    end
    enable = 1'b0;
  endtask

`ifdef SEG_SCAN_LZB_EN
  task automatic test_lzb();
    logic [15:0] val;
    logic [3:0]  ea;
    int          d;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      val = (t == 0) ? 16'h0050 : 16'h0000;
      start(val);
      for (int c = 0; c < 24; c++) begin
        step();
        d  = c / 6;
        ea = 4'hF;
        if ((c % 6) >= 2) begin
          if (t == 0 && d <= 1) ea[d] = 1'b0;
          if (t == 1 && d == 0) ea[d] = 1'b0;
        end
        checks++;
        if (an !== ea || seg_bcd !== val[d*4 +: 4]) begin
          errors++;
          $display("FAIL lzb t=%0d c=%0d: an=%b seg=%h want %b %h",
                   t, c, an, seg_bcd, ea, val[d*4 +: 4]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_no_tearing();
    test_load_boundary();
    test_enable_reset();
`ifdef SEG_SCAN_LZB_EN
    test_lzb();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
